// File: rtl/uart_pkg.sv
// Shared constants, FSM encoding and sizing helpers for the parametrised UART transmitter.
package uart_pkg;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } tx_state_t;

  // Bit period in clock cycles; integer division truncates.
  function automatic int baud_cnt(input int clk_freq, input int uart_bps);
    return clk_freq / uart_bps;
  endfunction

  function automatic int frame_bits(input int data_bits, input int parity, input int stop_bits);
    return 1 + data_bits + ((parity != PARITY_NONE) ? 1 : 0) + stop_bits;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Small synchronous FIFO with first-word fall-through read data.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_reg;
  logic [AW:0]      rd_ptr_reg;
  logic             do_wr;
  logic             do_rd;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign count   = wr_ptr_reg - rd_ptr_reg;
  assign full    = (count == (AW + 1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr_reg[AW-1:0]];

  always_ff @(posedge sys_clk) begin
    if (do_wr) begin
      mem[wr_ptr_reg[AW-1:0]] <= wr_data;
    end
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
    end else begin
      if (do_wr) wr_ptr_reg <= wr_ptr_reg + (AW + 1)'(1);
      if (do_rd) rd_ptr_reg <= rd_ptr_reg + (AW + 1)'(1);
    end
  end

endmodule

// File: rtl/uart_tx_frame.sv
// UART transmitter with configurable frame format and a valid/ready FIFO front end;
// queued words go out back-to-back with no idle gap between frames.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 50000000,
  parameter int UART_BPS   = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst,
  input  logic                          uart_tx_valid,
  output logic                          uart_tx_ready,
  input  logic [DATA_BITS-1:0]          uart_din,
  output logic                          uart_txd,
  output logic                          uart_tx_busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int                BPS_CNT   = baud_cnt(CLK_FREQ, UART_BPS);
  localparam int                BAUD_W    = (BPS_CNT > 1) ? $clog2(BPS_CNT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(BPS_CNT - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  tx_state_t              state_reg, state_next;
  logic [BAUD_W-1:0]      baud_reg, baud_next;
  logic [3:0]             bit_reg, bit_next;
  logic [DATA_BITS-1:0]   shift_reg, shift_next;
  logic                   par_reg, par_next;
  logic                   busy_reg, busy_next;
  logic                   txd_reg, txd_next;
  logic                   bit_end;
  logic                   load;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic [DATA_BITS-1:0]   fifo_data;

  function automatic logic calc_par(input logic [DATA_BITS-1:0] word);
    return (PARITY == PARITY_ODD) ? ~^word : ^word;
  endfunction

  uart_tx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .wr_en   (uart_tx_valid),
    .wr_data (uart_din),
    .rd_en   (load),
    .rd_data (fifo_data),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign uart_tx_ready = !fifo_full;
  assign uart_tx_busy  = busy_reg;
  assign uart_txd      = txd_reg;
  assign bit_end       = (baud_reg == BAUD_LAST);

  always_comb begin
    state_next = state_reg;
    baud_next  = bit_end ? '0 : baud_reg + BAUD_W'(1);
    bit_next   = bit_reg;
    shift_next = shift_reg;
    par_next   = par_reg;
    load       = 1'b0;
    case (state_reg)
      IDLE: begin
        baud_next = '0;
        load      = !fifo_empty;
      end
      START: begin
        if (bit_end) begin
          state_next = DATA;
          bit_next   = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_next = shift_reg >> 1;
          if (bit_reg == DATA_LAST) begin
            bit_next   = '0;
            state_next = (PARITY != PARITY_NONE) ? PAR : STOP;
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end
      end
      PAR: begin
        if (bit_end) begin
          bit_next   = '0;
          state_next = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          if (bit_reg == STOP_LAST) begin
            bit_next   = '0;
            state_next = IDLE;
            load       = !fifo_empty;
          end else begin
            bit_next = bit_reg + 4'd1;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    // Popping from IDLE or the last stop cycle both start a fresh frame at this edge.
    if (load) begin
      state_next = START;
      baud_next  = '0;
      bit_next   = '0;
      shift_next = fifo_data;
      par_next   = calc_par(fifo_data);
    end
  end

  // The line flop decodes the current state, so it trails the FSM by one cycle.
  always_comb begin
    txd_next = 1'b1;
    case (state_reg)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shift_reg[0];
      PAR:     txd_next = par_reg;
      default: txd_next = 1'b1;
    endcase
  end

  assign busy_next = (state_next != IDLE) || !fifo_empty;

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_reg <= IDLE;
      baud_reg  <= '0;
      bit_reg   <= '0;
      shift_reg <= '0;
      par_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      txd_reg   <= 1'b1;
    end else begin
      state_reg <= state_next;
      baud_reg  <= baud_next;
      bit_reg   <= bit_next;
      shift_reg <= shift_next;
      par_reg   <= par_next;
      busy_reg  <= busy_next;
      txd_reg   <= txd_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Bench for uart_tx_frame: five differently configured instances, a frame receiver and a scoreboard.
module tb_uart_tx_frame;
  import uart_pkg::*;

  localparam int DEF_BPS  = baud_cnt(50000000, 115200);
  localparam int FAST_BPS = baud_cnt(1000000, 100000);
  localparam int NINST    = 5;

  typedef struct {
    int          s;
    logic [8:0]  data;
    int          nbits;
    int          bps;
    logic [15:0] exp;
  } row_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       valid [NINST];
  logic [8:0] din   [NINST];
  logic       txd   [NINST];
  logic       busy  [NINST];
  logic       ready [NINST];
  logic [2:0] cnt   [NINST];

  int          checks = 0;
  int          errors = 0;
  logic [15:0] exp_q[$];
  row_t        rows [6];

  always #5 clk = ~clk;

  uart_tx_frame u_def (
    .sys_clk(clk), .sys_rst(rst), .uart_tx_valid(valid[0]), .uart_tx_ready(ready[0]),
    .uart_din(din[0][7:0]), .uart_txd(txd[0]), .uart_tx_busy(busy[0]), .fifo_count(cnt[0]));

  uart_tx_frame #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(PARITY_EVEN)) u_even (
    .sys_clk(clk), .sys_rst(rst), .uart_tx_valid(valid[1]), .uart_tx_ready(ready[1]),
    .uart_din(din[1][7:0]), .uart_txd(txd[1]), .uart_tx_busy(busy[1]), .fifo_count(cnt[1]));

  uart_tx_frame #(.CLK_FREQ(1000000), .UART_BPS(100000), .PARITY(PARITY_ODD)) u_odd (
    .sys_clk(clk), .sys_rst(rst), .uart_tx_valid(valid[2]), .uart_tx_ready(ready[2]),
    .uart_din(din[2][7:0]), .uart_txd(txd[2]), .uart_tx_busy(busy[2]), .fifo_count(cnt[2]));

  uart_tx_frame #(.CLK_FREQ(1000000), .UART_BPS(100000), .DATA_BITS(7), .STOP_BITS(2)) u_d7 (
    .sys_clk(clk), .sys_rst(rst), .uart_tx_valid(valid[3]), .uart_tx_ready(ready[3]),
    .uart_din(din[3][6:0]), .uart_txd(txd[3]), .uart_tx_busy(busy[3]), .fifo_count(cnt[3]));

  uart_tx_frame #(.CLK_FREQ(1000000), .UART_BPS(100000)) u_fast (
    .sys_clk(clk), .sys_rst(rst), .uart_tx_valid(valid[4]), .uart_tx_ready(ready[4]),
    .uart_din(din[4][7:0]), .uart_txd(txd[4]), .uart_tx_busy(busy[4]), .fifo_count(cnt[4]));

  task automatic check(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  function automatic logic [15:0] make_frame(input logic [8:0] data, input int dbits,
                                             input int par, input int stop);
    logic [15:0] f;
    int          idx;
    logic        p;
    f   = '0;
    idx = 1;
    p   = 1'b0;
    for (int i = 0; i < dbits; i++) begin
      f[idx] = data[i];
      p      = p ^ data[i];
      idx++;
    end
    if (par != PARITY_NONE) begin
      f[idx] = (par == PARITY_ODD) ? ~p : p;
      idx++;
    end
    for (int i = 0; i < stop; i++) begin
      f[idx] = 1'b1;
      idx++;
    end
    return f;
  endfunction

  // Called at a negedge; returns at the negedge after the accepting posedge with valid still high.
  task automatic send(input int s, input logic [8:0] w, input logic [15:0] exp, output int waited);
    din[s]   = w;
    valid[s] = 1'b1;
    waited   = 0;
    while (ready[s] !== 1'b1 && waited < 20000) begin
      @(negedge clk);
      waited++;
    end
    if (ready[s] !== 1'b1) check($sformatf("send_timeout[%0d]", s), 0, 1);
    else exp_q.push_back(exp);
    @(negedge clk);
  endtask

  // Samples every negedge; each bit must stay constant for exactly bps cycles.
  task automatic capture(input int s, input int nbits, input int bps, input int max_wait,
                         output logic [15:0] bits, output int waited, output int busy_cnt,
                         output bit stable);
    bits     = '0;
    waited   = 0;
    busy_cnt = 0;
    stable   = 1'b1;
    while (txd[s] !== 1'b0 && waited < max_wait) begin
      if (busy[s] === 1'b1) busy_cnt++;
      waited++;
      @(negedge clk);
    end
    if (txd[s] !== 1'b0) begin
      stable = 1'b0;
      bits   = '1;
      return;
    end
    for (int b = 0; b < nbits; b++) begin
      for (int c = 0; c < bps; c++) begin
        if (c == 0) bits[b] = txd[s];
        else if (txd[s] !== bits[b]) stable = 1'b0;
        if (busy[s] === 1'b1) busy_cnt++;
        @(negedge clk);
      end
    end
  endtask

  task automatic run_monitor(input int s, input int nframes, input int nbits, input int bps);
    logic [15:0] bits;
    logic [15:0] exp;
    int          w;
    int          bc;
    bit          st;
    for (int k = 0; k < nframes; k++) begin
      capture(s, nbits, bps, (k == 0) ? 10 : 0, bits, w, bc, st);
      check($sformatf("contiguous_stable[%0d.%0d]", s, k), st, 1);
      if (exp_q.size() == 0) begin
        check($sformatf("sb_underflow[%0d.%0d]", s, k), 0, 1);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("frame[%0d.%0d]", s, k), bits, exp);
        $display("inst %0d frame %0d: bits=%h expected=%h", s, k, bits, exp);
      end
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] bits;
    logic [15:0] exp;
    int          w;
    int          bc;
    int          n;
    int          bad;
    int          blocked_at;
    bit          st;

    rows[0] = '{0, 9'h0A5, frame_bits(8, PARITY_NONE, 1), DEF_BPS,  16'h034A};
    rows[1] = '{1, 9'h0A5, frame_bits(8, PARITY_EVEN, 1), FAST_BPS, 16'h054A};
    rows[2] = '{1, 9'h007, frame_bits(8, PARITY_EVEN, 1), FAST_BPS, 16'h060E};
    rows[3] = '{2, 9'h0A5, frame_bits(8, PARITY_ODD,  1), FAST_BPS, 16'h074A};
    rows[4] = '{3, 9'h041, frame_bits(7, PARITY_NONE, 2), FAST_BPS, 16'h0382};
    rows[5] = '{4, 9'h03C, frame_bits(8, PARITY_NONE, 1), FAST_BPS, 16'h0278};

    rst = 1'b1;
    for (int i = 0; i < NINST; i++) begin
      valid[i] = 1'b0;
      din[i]   = '0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NINST; i++) begin
      check($sformatf("reset_txd[%0d]", i), txd[i], 1);
      check($sformatf("reset_busy[%0d]", i), busy[i], 0);
      check($sformatf("reset_ready[%0d]", i), ready[i], 1);
      check($sformatf("reset_count[%0d]", i), cnt[i], 0);
    end
    rst = 1'b0;
    @(negedge clk);

    // Single frames: format, parity, latency, busy window, and din changes after the push.
    for (int r = 0; r < 6; r++) begin
      send(rows[r].s, rows[r].data, rows[r].exp, w);
      valid[rows[r].s] = 1'b0;
      din[rows[r].s]   = ~rows[r].data;
      capture(rows[r].s, rows[r].nbits, rows[r].bps, 5, bits, w, bc, st);
      check($sformatf("latency[%0d]", r), w, 2);
      check($sformatf("bit_hold[%0d]", r), st, 1);
      check($sformatf("busy_cycles[%0d]", r), bc, rows[r].nbits * rows[r].bps);
      if (exp_q.size() == 0) begin
        check($sformatf("sb_underflow[%0d]", r), 0, 1);
      end else begin
        exp = exp_q.pop_front();
        check($sformatf("frame[%0d]", r), bits, exp);
        $display("row %0d inst %0d data=%h: bits=%h expected=%h", r, rows[r].s, rows[r].data, bits, exp);
      end
      check($sformatf("idle_txd[%0d]", r), txd[rows[r].s], 1);
      check($sformatf("idle_busy[%0d]", r), busy[rows[r].s], 0);
    end

    // Six words offered on consecutive cycles into a 4-deep FIFO.
    blocked_at = -1;
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (ready[0] !== 1'b1 && blocked_at < 0) begin
            blocked_at = i;
            check("full_count", cnt[0], 4);
          end
          send(0, 9'(8'h11 + i), make_frame(9'(8'h11 + i), 8, PARITY_NONE, 1), w);
          // Word 0x16 waits for the pop on the last stop cycle of frame one.
          if (i == 5) check("wait_for_space", w, 4337);
        end
        valid[0] = 1'b0;
      end
      run_monitor(0, 6, 10, DEF_BPS);
    join
    check("blocked_at", blocked_at, 5);
    check("burst_end_txd", txd[0], 1);
    check("burst_end_busy", busy[0], 0);

    // Reset in the middle of data bit 3 with two words still queued.
    for (int i = 0; i < 3; i++) send(0, 9'(8'h31 + i), 16'h0, w);
    valid[0] = 1'b0;
    check("queued_before_reset", cnt[0], 2);
    n = 0;
    while (txd[0] !== 1'b0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("start_before_reset", txd[0], 0);
    repeat (4 * DEF_BPS + 200) @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_reset_txd", txd[0], 1);
    check("mid_reset_busy", busy[0], 0);
    check("mid_reset_count", cnt[0], 0);
    check("mid_reset_ready", ready[0], 1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (txd[0] !== 1'b1 || busy[0] !== 1'b0) bad++;
    end
    check("quiet_after_reset", bad, 0);
    $display("reset mid-frame: %0d bad idle samples", bad);

    // A word offered while full is replaced before it can be accepted.
    fork
      begin
        for (int i = 0; i < 5; i++) send(4, 9'(8'h21 + i), make_frame(9'(8'h21 + i), 8, PARITY_NONE, 1), w);
        din[4] = 9'h05A;
        for (int i = 0; i < 3; i++) begin
          check($sformatf("full_ready[%0d]", i), ready[4], 0);
          @(negedge clk);
        end
        send(4, 9'h03C, make_frame(9'h03C, 8, PARITY_NONE, 1), w);
        valid[4] = 1'b0;
      end
      run_monitor(4, 6, 10, FAST_BPS);
    join
    check("held_word_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised successor to the fixed 8N1 UART transmitter.
- Configurable data width, parity mode and stop-bit count.
- Valid/ready input handshake in front of a small internal FIFO, so words are sent back-to-back with no idle gap.
- Sits between a byte/word producer (command or debug logic) and the board TX pin.

Parameters:
- CLK_FREQ, 50000000: system clock frequency in Hz.
- UART_BPS, 115200: baud rate. Bit period BPS_CNT = CLK_FREQ/UART_BPS, truncated (434 at defaults).
- DATA_BITS, 8: data bits per frame, legal 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: legal 1 or 2.
- FIFO_DEPTH, 4: input FIFO entries, power of two, at least 2.

Ports:
- sys_clk, input, 1: system clock. One clock domain only.
- sys_rst, input, 1: reset, asynchronous, active-high.
- uart_tx_valid, input, 1: producer has a word on uart_din.
- uart_tx_ready, output, 1: FIFO can accept a word.
- uart_din, input, DATA_BITS: word to send; LSB is transmitted first.
- uart_txd, output, 1: serial line, idles high.
- uart_tx_busy, output, 1: FIFO non-empty or a frame is in progress.
- fifo_count, output, $clog2(FIFO_DEPTH)+1: number of words held in the FIFO.

Behaviour:
- Reset values, applied asynchronously: uart_txd=1, uart_tx_busy=0, uart_tx_ready=1, fifo_count=0, FSM=IDLE, all counters 0.
- Push: a word is written when uart_tx_valid && uart_tx_ready at a sys_clk edge.
  - uart_tx_ready = !full, combinational from the FIFO pointers.
  - A word offered while full is not accepted; the producer holds it.
- Pop and push in the same cycle: fifo_count is unchanged. When full, ready=0, so only the pop occurs.
- FSM states: IDLE, START, DATA, PAR, STOP.
- IDLE:
  - uart_txd=1.
  - If FIFO non-empty: pop at the edge, latch the word into the shift register, go to START, drive uart_txd=0 from that edge.
  - Latency from an accepted push into an empty idle block: txd falls 2 edges after the push edge.
- START: hold uart_txd=0 for BPS_CNT cycles, then go to DATA.
- DATA:
  - Shift out DATA_BITS bits, LSB first, each held BPS_CNT cycles.
  - Then go to PAR if PARITY!=0, else to STOP.
- PAR:
  - Even parity: bit = XOR of the data bits.
  - Odd parity: bit = its inverse.
  - Held BPS_CNT cycles, then go to STOP.
- STOP: uart_txd=1 for STOP_BITS*BPS_CNT cycles. On the final cycle:
  - If FIFO non-empty: pop and go directly to START. The next start bit begins on the very next cycle, with no extra idle cycle.
  - Otherwise go to IDLE.
- Frame length is exactly (1 + DATA_BITS + (PARITY!=0) + STOP_BITS) * BPS_CNT cycles.
- Baud counter:
  - Counts 0..BPS_CNT-1 and resets at every bit boundary.
  - Its width is sized from BPS_CNT.
  - The counter starts at 0 on the START entry edge.
- uart_tx_busy is registered: high from the edge after the first push until the edge on which the FSM returns to IDLE with the FIFO empty.
- uart_txd is driven from a flop; no combinational path from any input.
- Reset mid-frame: the line returns high immediately, the FIFO is flushed, and the word in flight is discarded and not resumed.
- uart_din is only sampled on push; changing it mid-frame has no effect.

Decomposition:
- Package uart_pkg holds:
  - Parity constants PARITY_NONE/ODD/EVEN.
  - FSM state encoding.
  - Function baud_cnt(CLK_FREQ, UART_BPS).
  - Function frame_bits(DATA_BITS, PARITY, STOP_BITS), also used by the bench.
- One sub-module: uart_tx_fifo.
  - Synchronous FIFO: sys_clk, sys_rst, parameters WIDTH and DEPTH.
  - Ports: wr_en, wr_data, rd_en, rd_data, full, empty, count.
  - rd_data is valid combinationally while !empty (first-word fall-through).

Test Plan:
1. Defaults (8N1, BPS_CNT=434); push 0xA5 once -> txd bits 0,1,0,1,0,0,1,0,1,1 (start, LSB-first data, stop), each held 434 cycles. busy high for 4340 cycles, then txd=1 and busy=0.
2. PARITY=2 with 0xA5 -> parity bit 0. PARITY=2 with 0x07 -> parity bit 1. PARITY=1 with 0xA5 -> parity bit 1. Frame is 11 bit periods.
3. DATA_BITS=7, STOP_BITS=2, CLK_FREQ=1000000, UART_BPS=100000 (BPS_CNT=10); push 7'h41 -> frame of 100 cycles, stop high for 20 cycles.
4. FIFO_DEPTH=4; hold valid high for 6 consecutive cycles with words 0x11..0x16:
   - Words 0x11..0x15 are accepted; ready drops with fifo_count=4.
   - 0x16 is accepted only after the first frame ends.
   - All 6 frames are contiguous: each start bit immediately follows the previous stop bit.
5. Assert sys_rst during data bit 3 with 2 words queued -> in the same cycle txd=1, busy=0, fifo_count=0, ready=1. After release with no push, txd stays 1 for 10000 cycles.
6. Push while full, with valid held and din changed -> the rejected value is never transmitted; the value present when ready rises is transmitted.
